ex_mem: RTL and testbench

Execute stage plus EX/MEM pipeline register for the 5-stage RV32I core. It consumes the control, operand and immediate fields launched by the decode-side ID/EX register. It applies MEM/WB forwarding, computes the ALU result, resolves BEQ-style branches, and registers the MEM-stage bundle. The PC redirect toward fetch and the hazard logic is combinational in the same cycle.

---
 rtl/ex_mem.sv | 125 ++++++++++++
 tb/tb_ex_mem.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// Execute stage with EX/MEM pipeline register: forwarding, ALU, branch resolve.
// Define EX_FORWARDING_EN to enable MEM/WB operand forwarding.
module ex_mem #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PCW  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWrite_E,
    input  logic            ALUSrc_E,
    input  logic            MemWrite_E,
    input  logic            MemToReg_E,
    input  logic            Branch_E,
    input  logic            MemRead_E,
    input  logic [XLEN-1:0] Rd1_E,
    input  logic [XLEN-1:0] Rd2_E,
    input  logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] intermediate,
    input  logic [4:0]      Rd_E,
    input  logic [4:0]      Rs1_E,
    input  logic [4:0]      Rs2_E,
    input  logic [PCW-1:0]  current_pc_E,
    input  logic [XLEN-1:0] Result_W,
    input  logic            RegWrite_W,
    input  logic [4:0]      Rd_W,
    output logic            RegWrite_M,
    output logic            MemWrite_M,
    output logic            MemToReg_M,
    output logic            MemRead_M,
    output logic [XLEN-1:0] ALUResult_M,
    output logic [XLEN-1:0] WriteData_M,
    output logic [4:0]      Rd_M,
    output logic            PCSrc_E,
    output logic [PCW-1:0]  PCTarget_E
);

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000,
        AluSub  = 4'b0001,
        AluAnd  = 4'b0010,
        AluOr   = 4'b0011,
        AluXor  = 4'b0100,
        AluSll  = 4'b0101,
        AluSrl  = 4'b0110,
        AluSra  = 4'b0111,
        AluSlt  = 4'b1000,
        AluSltu = 4'b1001
    } alu_op_e;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      shamt;

`ifdef EX_FORWARDING_EN
    // MEM is the younger producer, so it takes priority over WB.
    always_comb begin
        src_a = Rd1_E;
        if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs1_E)) begin
            src_a = ALUResult_M;
        end else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs1_E)) begin
            src_a = Result_W;
        end
    end

    always_comb begin
        rs2_fwd = Rd2_E;
        if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs2_E)) begin
            rs2_fwd = ALUResult_M;
        end else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs2_E)) begin
            rs2_fwd = Result_W;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{Result_W, RegWrite_W, Rd_W, Rs1_E, Rs2_E};
    assign src_a      = Rd1_E;
    assign rs2_fwd    = Rd2_E;
`endif

    assign src_b = ALUSrc_E ? intermediate : rs2_fwd;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_result = '0;
        case (ALUControl)
            AluAdd:  alu_result = src_a + src_b;
            AluSub:  alu_result = src_a - src_b;
            AluAnd:  alu_result = src_a & src_b;
            AluOr:   alu_result = src_a | src_b;
            AluXor:  alu_result = src_a ^ src_b;
            AluSll:  alu_result = src_a << shamt;
            AluSrl:  alu_result = src_a >> shamt;
            AluSra:  alu_result = $unsigned($signed(src_a) >>> shamt);
            AluSlt:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            AluSltu: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default: alu_result = '0;
        endcase
    end

    assign PCSrc_E    = !reset && Branch_E && (src_a == rs2_fwd);
    assign PCTarget_E = current_pc_E + intermediate[PCW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite_M  <= 1'b0;
            MemWrite_M  <= 1'b0;
            MemToReg_M  <= 1'b0;
            MemRead_M   <= 1'b0;
            ALUResult_M <= '0;
            WriteData_M <= '0;
            Rd_M        <= '0;
        end else begin
            RegWrite_M  <= RegWrite_E;
            MemWrite_M  <= MemWrite_E;
            MemToReg_M  <= MemToReg_E;
            MemRead_M   <= MemRead_E;
            ALUResult_M <= alu_result;
            WriteData_M <= rs2_fwd;
            Rd_M        <= Rd_E;
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for ex_mem; expectations follow EX_FORWARDING_EN.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_E, ALUSrc_E, MemWrite_E, MemToReg_E, Branch_E, MemRead_E;
    logic [31:0] Rd1_E, Rd2_E, intermediate, Result_W;
    logic [3:0]  ALUControl;
    logic [4:0]  Rd_E, Rs1_E, Rs2_E, Rd_W;
    logic [9:0]  current_pc_E;
    logic        RegWrite_W;
    logic        RegWrite_M, MemWrite_M, MemToReg_M, MemRead_M, PCSrc_E;
    logic [31:0] ALUResult_M, WriteData_M;
    logic [4:0]  Rd_M;
    logic [9:0]  PCTarget_E;

    int n_total = 0;
    int n_bad   = 0;

    ex_mem #(.XLEN(32), .PCW(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite_E   (RegWrite_E),
        .ALUSrc_E     (ALUSrc_E),
        .MemWrite_E   (MemWrite_E),
        .MemToReg_E   (MemToReg_E),
        .Branch_E     (Branch_E),
        .MemRead_E    (MemRead_E),
        .Rd1_E        (Rd1_E),
        .Rd2_E        (Rd2_E),
        .ALUControl   (ALUControl),
        .intermediate (intermediate),
        .Rd_E         (Rd_E),
        .Rs1_E        (Rs1_E),
        .Rs2_E        (Rs2_E),
        .current_pc_E (current_pc_E),
        .Result_W     (Result_W),
        .RegWrite_W   (RegWrite_W),
        .Rd_W         (Rd_W),
        .RegWrite_M   (RegWrite_M),
        .MemWrite_M   (MemWrite_M),
        .MemToReg_M   (MemToReg_M),
        .MemRead_M    (MemRead_M),
        .ALUResult_M  (ALUResult_M),
        .WriteData_M  (WriteData_M),
        .Rd_M         (Rd_M),
        .PCSrc_E      (PCSrc_E),
        .PCTarget_E   (PCTarget_E)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        RegWrite_E = 0; ALUSrc_E = 0; MemWrite_E = 0; MemToReg_E = 0;
        Branch_E = 0; MemRead_E = 0;
        Rd1_E = 0; Rd2_E = 0; ALUControl = 4'b1111; intermediate = 0;
        Rd_E = 0; Rs1_E = 0; Rs2_E = 0; current_pc_E = 0;
        Result_W = 0; RegWrite_W = 0; Rd_W = 0;
    endtask

    // Inputs change 1 ns after the active edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_case(input string tag, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        clear_inputs();
        ALUControl = op;
        Rd1_E      = a;
        Rd2_E      = b;
        step();
        check(tag, ALUResult_M, exp);
    endtask

    logic [31:0] exp_v;

    initial begin
        // Reset with random inputs; equal rs indices make an unreset branch resolve taken.
        reset        = 1;
        RegWrite_E   = 1'($urandom); ALUSrc_E = 1'($urandom); MemWrite_E = 1;
        MemToReg_E   = 1; MemRead_E = 1; Branch_E = 1;
        Rd1_E        = 32'h1234; Rd2_E = 32'h1234; ALUControl = 4'($urandom);
        intermediate = $urandom; Rd_E = 5'd7; Rs1_E = 5'd4; Rs2_E = 5'd4;
        current_pc_E = 10'($urandom); Result_W = $urandom;
        RegWrite_W   = 1'($urandom); Rd_W = 5'($urandom);
        #3;
        check("rst_alu", ALUResult_M, 0);
        check("rst_rd", {27'd0, Rd_M}, 0);
        check("rst_ctrl", {28'd0, RegWrite_M, MemWrite_M, MemToReg_M, MemRead_M}, 0);
        check("rst_wdata", WriteData_M, 0);
        check("rst_pcsrc", {31'd0, PCSrc_E}, 0);
        step();
        check("rst_hold", {28'd0, RegWrite_M, MemWrite_M, MemToReg_M, MemRead_M}, 0);

        // Release and issue ADD x3 = 5 + 7
        clear_inputs();
        reset = 0;
        ALUControl = 4'b0000; RegWrite_E = 1; Rd_E = 5'd3;
        Rd1_E = 5; Rd2_E = 7; Rs1_E = 5'd1; Rs2_E = 5'd2;
        step();
        check("add_res", ALUResult_M, 12);
        check("add_rd", {27'd0, Rd_M}, 3);
        check("add_rw", {31'd0, RegWrite_M}, 1);

        alu_case("sub",  4'b0001, 3, 5, 32'hFFFF_FFFE);
        alu_case("and",  4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu_case("or",   4'b0011, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
        alu_case("xor",  4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        alu_case("sll",  4'b0101, 1, 32'h24, 32'h10);
        alu_case("sra",  4'b0111, 32'h8000_0000, 4, 32'hF800_0000);
        alu_case("srl",  4'b0110, 32'h8000_0000, 4, 32'h0800_0000);
        alu_case("slt",  4'b1000, 32'hFFFF_FFFF, 1, 1);
        alu_case("sltu", 4'b1001, 32'hFFFF_FFFF, 1, 0);
        alu_case("nop",  4'b1111, 32'h1234_5678, 32'h9, 0);
        alu_case("undef", 4'b1010, 32'h1234_5678, 32'h9, 0);
        alu_case("addwrap", 4'b0000, 32'hFFFF_FFFF, 2, 1);

        // Forwarding priority: MEM x5 = 0xAA, WB x5 = 0xBB
        clear_inputs();
        ALUControl = 4'b0000; RegWrite_E = 1; Rd_E = 5'd5; Rd1_E = 32'hAA;
        step();
        clear_inputs();
        ALUControl = 4'b0000; ALUSrc_E = 1; Rs1_E = 5'd5; Rd1_E = 32'h11;
        RegWrite_W = 1; Rd_W = 5'd5; Result_W = 32'hBB;
        step();
`ifdef EX_FORWARDING_EN
        exp_v = 32'hAA;
`else
        exp_v = 32'h11;
`endif
        check("fwd_mem_pri", ALUResult_M, exp_v);

        // Producer writes x0: MEM must not forward, WB takes over
        clear_inputs();
        ALUControl = 4'b0000; RegWrite_E = 1; Rd_E = 5'd0; Rd1_E = 32'hAA;
        step();
        clear_inputs();
        ALUControl = 4'b0000; ALUSrc_E = 1; Rs1_E = 5'd5; Rd1_E = 32'h11;
        RegWrite_W = 1; Rd_W = 5'd5; Result_W = 32'hBB;
        step();
`ifdef EX_FORWARDING_EN
        exp_v = 32'hBB;
`else
        exp_v = 32'h11;
`endif
        check("fwd_wb", ALUResult_M, exp_v);

        // Branch, combinational in the same cycle
        clear_inputs();
        Branch_E = 1; Rd1_E = 9; Rd2_E = 9;
        current_pc_E = 10'h3F8; intermediate = 32'h10;
        #1;
        check("br_taken", {31'd0, PCSrc_E}, 1);
        check("br_target", {22'd0, PCTarget_E}, 32'h008);
        Rd2_E = 8;
        #1;
        check("br_nottaken", {31'd0, PCSrc_E}, 0);
        step();

        // Store with rs2 from WB
        clear_inputs();
        step();
        clear_inputs();
        ALUControl = 4'b0000; MemWrite_E = 1; ALUSrc_E = 1; intermediate = 8;
        Rd1_E = 32'h100; Rs2_E = 5'd6; Rd2_E = 32'h99;
        RegWrite_W = 1; Rd_W = 5'd6; Result_W = 32'h55;
        step();
`ifdef EX_FORWARDING_EN
        exp_v = 32'h55;
`else
        exp_v = 32'h99;
`endif
        check("st_addr", ALUResult_M, 32'h108);
        check("st_data", WriteData_M, exp_v);
        check("st_mw", {31'd0, MemWrite_M}, 1);

        // Load then bubble
        clear_inputs();
        ALUControl = 4'b0000; RegWrite_E = 1; MemRead_E = 1; MemToReg_E = 1;
        Rd_E = 5'd9; ALUSrc_E = 1; intermediate = 4;
        step();
        check("ld_ctrl", {28'd0, RegWrite_M, MemWrite_M, MemToReg_M, MemRead_M}, 32'hB);
        clear_inputs();
        step();
        check("bubble_ctrl", {29'd0, RegWrite_M, MemWrite_M, MemRead_M}, 0);
        check("bubble_pcsrc", {31'd0, PCSrc_E}, 0);

        // Asynchronous reset mid-stream drops the in-flight instruction
        clear_inputs();
        ALUControl = 4'b0000; RegWrite_E = 1; Rd_E = 5'd4; Rd1_E = 32'h77;
        step();
        check("pre_rst", ALUResult_M, 32'h77);
        #2;
        reset = 1;
        #1;
        check("async_rst_alu", ALUResult_M, 0);
        check("async_rst_rw", {31'd0, RegWrite_M}, 0);
        @(negedge clk);
        reset = 0;
        Rd1_E = 32'h33; Rd_E = 5'd8;
        step();
        check("post_rst_alu", ALUResult_M, 32'h33);
        check("post_rst_rd", {27'd0, Rd_M}, 8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
